uart_xcvr: RTL
==============

// Module: uart_xcvr
// PURPOSE
//  Parametrised full-duplex UART transceiver. Next generation of uart_core.
//  Adds an internal programmable baud-tick generator, valid/ready handshakes on TX and RX,
//  an RX input synchroniser, 3-sample majority voting, a glitch-rejecting start check,
//  break detection and overrun detection.
//  Sits between the tt_um_* pad wrapper and user logic. Per-frame settings come from cfg_* ports.
// PARAMETERS
//  DIV_W        16  width of cfg_div (baud tick divider)
//  OVERSAMPLE   16  ticks per bit; even, >=8
//  SYNC_STAGES  2   rx_in synchroniser flops, >=2
// PORTS
//  clk            in   1      single clock
//  rst_n          in   1      synchronous, active-low reset
//  cfg_div        in   DIV_W  tick every cfg_div+1 clocks
//  cfg_bits       in   2      data bits = 5+cfg_bits (5..8)
//  cfg_par_en     in   1      parity bit present
//  cfg_par_odd    in   1      1=odd, 0=even parity
//  cfg_stop2      in   1      TX sends 2 stop bits
//  tx_data        in   8      LSB-first; bits above data length ignored
//  tx_valid       in   1      TX request
//  tx_ready       out  1      TX idle, can accept
//  tx_out         out  1      serial out, idle high
//  rx_in          in   1      serial in, asynchronous
//  rx_data        out  8      right-aligned, unused upper bits 0
//  rx_valid       out  1      rx_data and flags valid
//  rx_ready       in   1      consumer accepts
//  rx_par_err     out  1      parity mismatch for held frame
//  rx_frm_err     out  1      stop bit sampled low for held frame
//  rx_break       out  1      held frame was a break
//  rx_overrun     out  1      sticky: a completed frame was dropped
// BEHAVIOUR
//  Reset (rst_n low at clk edge):
//   - tx_out=1, tx_ready=1, rx_valid=0, all flags 0, rx_data=0.
//   - Both FSMs go to IDLE. Synchroniser flops and divider counter reset to 1 and 0.
//   - A mid-frame reset aborts the frame at that edge.
//  Tick: counter 0..cfg_div; one-clock tick when count==cfg_div, then reload 0.
//   - cfg_div=0 gives a tick every clock. One tick feeds both TX and RX.
//  TX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE. Each bit lasts OVERSAMPLE ticks.
//   - Accept on tx_valid&&tx_ready in IDLE. Data and cfg_* are snapshotted; tx_ready drops next clock.
//   - The first bit period starts at the first tick after accept.
//   - tx_out is registered. START=0, DATA LSB first, PARITY = XOR of data (inverted for odd... see next line).
//   - Parity: even -> ^data; odd -> ~^data. STOP=1 for 1 or 2 bit periods.
//   - tx_ready returns 1 the clock after the last stop tick. Back-to-back accept in that clock is allowed.
//  RX: rx_in passes the synchroniser to give rs. Majority = 2-of-3 samples at ticks OS/2-1, OS/2, OS/2+1.
//   - IDLE: a falling edge on rs enters START and snapshots cfg_*.
//   - START: vote low -> DATA; vote high -> IDLE (glitch rejected, nothing reported).
//   - DATA: shift the vote LSB first, 5+cfg_bits bits. Then PARITY if enabled, else STOP.
//   - PARITY: rx_par_err = vote != expected parity.
//   - STOP: check the first stop bit only. rx_frm_err = vote==0.
//   - rx_break = frm_err && all data bits 0 && parity bit 0 (if present).
//   - Completion at the stop-bit vote (mid-bit), not at the bit end.
//   - Next state: if stop vote=1 -> IDLE, so the next start edge is caught.
//     If stop vote=0 -> WAIT_HI, which goes to IDLE once rs==1.
//  RX holding register, one entry:
//   - On completion with rx_valid=0: load data and flags; rx_valid=1 next clock.
//   - rx_valid, rx_data and flags are held until rx_valid&&rx_ready; rx_valid=0 the clock after.
//   - Completion while rx_valid=1 and no handshake: new frame dropped, old one kept, rx_overrun=1.
//   - Handshake and completion in the same clock: new frame loaded, no overrun.
//   - rx_overrun clears on the next handshake.
//  cfg_* changes mid-frame have no effect until the next frame.
// STRUCTURE
//  uart_pkg: TX/RX state enums, OS_MID=OVERSAMPLE/2, calc_parity(data,bits,odd) function.
//  Sub-module uart_baud_gen (DIV_W): cfg_div -> tick. The rest is inline, with two FSM always blocks.
// TESTING
//  (OS=16, cfg_div=0, so 1 bit = 16 clk)
//  1. 8N1 tx 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1, each 16 clk; tx_ready low 160 clk, then high.
//  2. Loopback 7O2, tx 0x35 -> rx_data 0x35, par=1 on wire, no flags; TX busy for 11 bits.
//  3. rx_in low pulse of 5 clk -> start rejected; rx_valid stays 0, RX back in IDLE.
//  4. 8E1 frame 0x3C with parity bit flipped -> rx_valid=1, rx_data=0x3C, rx_par_err=1.
//  5. rx_in held low 20 bit times -> rx_data=0, rx_frm_err=1, rx_break=1.
//     No new frame until rx_in has gone high and then had a fresh falling edge.
//  6. Two frames with rx_ready=0 -> first kept, rx_overrun=1; handshake -> rx_valid=0, rx_overrun=0.
//     Reset asserted mid-TX -> tx_out=1, tx_ready=1 on that edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_xcvr transceiver.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HI
  } rx_state_t;

  localparam int OS_DEFAULT = 16;

  function automatic int os_mid(input int os);
    return os / 2;
  endfunction

  // Parity over the low 5+bits data bits; odd parity is the inverted XOR.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] bits,
                                       input logic odd);
    logic [7:0] masked;
    masked = data & (8'hff >> (2'd3 - bits));
    return (^masked) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable tick generator: one-clock tick every cfg_div+1 clocks.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divider lowered below the current count still wraps promptly.
  assign tick = (cnt >= cfg_div);

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART with valid/ready on both sides, majority-vote RX, break and overrun detection.
// Handshakes: a transfer happens on any clock edge where valid && ready are both high.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int OVERSAMPLE  = OS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_bits,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  input  logic             rx_in,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_par_err,
  output logic             rx_frm_err,
  output logic             rx_break,
  output logic             rx_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SMP_A   = CW'(os_mid(OVERSAMPLE) - 1);
  localparam logic [CW-1:0] SMP_B   = CW'(os_mid(OVERSAMPLE));
  localparam logic [CW-1:0] SMP_C   = CW'(os_mid(OVERSAMPLE) + 1);

  logic tick;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_div (cfg_div),
    .tick    (tick)
  );

  tx_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;
  logic [1:0]  tx_bits_q;
  logic        tx_par_en_q, tx_par_q, tx_stop2_q, tx_stop_second, tx_bit;

  always_comb begin
    tx_bit = 1'b1;
    case (tx_state)
      TX_START:  tx_bit = 1'b0;
      TX_DATA:   tx_bit = tx_sh[0];
      TX_PARITY: tx_bit = tx_par_q;
      default:   tx_bit = 1'b1;
    endcase
  end

  // The line level of a bit is driven on its first tick, so a bit holds for OVERSAMPLE ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state       <= TX_IDLE;
      tx_out         <= 1'b1;
      tx_ready       <= 1'b1;
      tx_cnt         <= '0;
      tx_idx         <= '0;
      tx_sh          <= '0;
      tx_bits_q      <= '0;
      tx_par_en_q    <= 1'b0;
      tx_par_q       <= 1'b0;
      tx_stop2_q     <= 1'b0;
      tx_stop_second <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      if (tx_valid && tx_ready) begin
        tx_state       <= TX_START;
        tx_ready       <= 1'b0;
        tx_cnt         <= '0;
        tx_sh          <= tx_data;
        tx_bits_q      <= cfg_bits;
        tx_par_en_q    <= cfg_par_en;
        tx_par_q       <= calc_parity(tx_data, cfg_bits, cfg_par_odd);
        tx_stop2_q     <= cfg_stop2;
        tx_stop_second <= 1'b0;
      end
    end else if (tick) begin
      if (tx_cnt == '0) tx_out <= tx_bit;
      if (tx_cnt == OS_LAST) begin
        tx_cnt <= '0;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_idx   <= '0;
          end
          TX_DATA: begin
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 3'd1;
            if (tx_idx == {1'b1, tx_bits_q}) tx_state <= tx_par_en_q ? TX_PARITY : TX_STOP;
          end
          TX_PARITY: tx_state <= TX_STOP;
          default: begin
            if (tx_stop2_q && !tx_stop_second) begin
              tx_stop_second <= 1'b1;
            end else begin
              tx_state <= TX_IDLE;
              tx_ready <= 1'b1;
            end
          end
        endcase
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  logic [SYNC_STAGES-1:0] sync;
  logic        rs, rs_prev, rx_s0, rx_s1, vote;
  rx_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh, rx_frame;
  logic [1:0]  rx_bits_q;
  logic        rx_par_en_q, rx_odd_q, rx_par_bit, rx_par_err_f;
  logic        done, brk_now;

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx_in};
  end

  assign rs       = sync[SYNC_STAGES-1];
  assign vote     = (rx_s0 & rx_s1) | (rx_s0 & rs) | (rx_s1 & rs);
  // Bits shift in from the top; realign so the frame is right-justified.
  assign rx_frame = rx_sh >> (2'd3 - rx_bits_q);
  assign done     = (rx_state == RX_STOP) && tick && (rx_cnt == SMP_C);
  assign brk_now  = !vote && (rx_frame == 8'd0) && !(rx_par_en_q && rx_par_bit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rs_prev      <= 1'b1;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_sh        <= '0;
      rx_bits_q    <= '0;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_s0        <= 1'b1;
      rx_s1        <= 1'b1;
      rx_par_bit   <= 1'b0;
      rx_par_err_f <= 1'b0;
    end else begin
      rs_prev <= rs;
      case (rx_state)
        RX_IDLE: begin
          if (rs_prev && !rs) begin
            rx_state     <= RX_START;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_sh        <= '0;
            rx_bits_q    <= cfg_bits;
            rx_par_en_q  <= cfg_par_en;
            rx_odd_q     <= cfg_par_odd;
            rx_par_bit   <= 1'b0;
            rx_par_err_f <= 1'b0;
          end
        end
        RX_WAIT_HI: if (rs) rx_state <= RX_IDLE;
        default: begin
          if (tick) begin
            rx_cnt <= (rx_cnt == OS_LAST) ? '0 : rx_cnt + 1'b1;
            if (rx_cnt == SMP_A) rx_s0 <= rs;
            if (rx_cnt == SMP_B) rx_s1 <= rs;
            case (rx_state)
              RX_START: begin
                if (rx_cnt == SMP_C && vote) rx_state <= RX_IDLE;
                else if (rx_cnt == OS_LAST)  rx_state <= RX_DATA;
              end
              RX_DATA: begin
                if (rx_cnt == SMP_C) rx_sh <= {vote, rx_sh[7:1]};
                if (rx_cnt == OS_LAST) begin
                  rx_idx <= rx_idx + 3'd1;
                  if (rx_idx == {1'b1, rx_bits_q}) rx_state <= rx_par_en_q ? RX_PARITY : RX_STOP;
                end
              end
              RX_PARITY: begin
                if (rx_cnt == SMP_C) begin
                  rx_par_bit   <= vote;
                  rx_par_err_f <= vote != calc_parity(rx_frame, rx_bits_q, rx_odd_q);
                end
                if (rx_cnt == OS_LAST) rx_state <= RX_STOP;
              end
              default: if (rx_cnt == SMP_C) rx_state <= vote ? RX_IDLE : RX_WAIT_HI;
            endcase
          end
        end
      endcase
    end
  end

  logic hs;
  assign hs = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_par_err <= 1'b0;
      rx_frm_err <= 1'b0;
      rx_break   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (done && (!rx_valid || hs)) begin
      rx_valid   <= 1'b1;
      rx_data    <= rx_frame;
      rx_par_err <= rx_par_err_f;
      rx_frm_err <= !vote;
      rx_break   <= brk_now;
      if (hs) rx_overrun <= 1'b0;
    end else if (done) begin
      rx_overrun <= 1'b1;
    end else if (hs) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule
